// File: rtl/dpram_stream_pkg.sv
// Shared types and helpers for the dual-port RAM stream reader.
package dpram_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int BUF_DEPTH = 2;

  // A new read may issue only if every word already owed to the buffer still fits.
  function automatic logic issue_credit(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return pending < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry synchronous FIFO holding {last,data} words returned from the RAM.
module stream_skid_fifo
  import dpram_stream_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ_q == 2'd2);
  assign empty   = (occ_q == 2'd0);
  assign occ     = occ_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset as well so the head reads zero straight out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst read initiator: issues RAM reads and re-times the registered data as a stream.
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  issue;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_occ;
  logic                  last_issue;

  assign pop        = out_valid && out_ready;
  assign last_issue = (rem_q == (ADDR_WIDTH+1)'(1));
  assign issue      = (state_q == RUN) && (rem_q != '0) &&
                      issue_credit(fifo_occ, inflight_q, pop);
  assign ram_ren    = issue;
  assign ram_raddr  = addr_q;
  assign cmd_ready  = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign out_valid  = !fifo_empty;

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_len == '0) ? DONE : RUN;
      RUN:     if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - (ADDR_WIDTH+1)'(1);
      end
      // Reset clears this flag, so a word returning after rst is never pushed.
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
    end
  end

  stream_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata ({inflight_last_q, ram_rdata}),
    .pop   (pop),
    .rdata ({out_last, out_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (fifo_occ)
  );

  // The credit rule means a returning word never meets a full buffer without a pop.
  assert property (@(posedge clk) disable iff (rst) !(fifo_full && inflight_q && !pop));

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader with a behavioural RAM and burst model.
module tb_dpram_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Registered-read RAM: data appears the cycle after ren and is held otherwise.
  always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

  dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  // mode 0: always ready, 1: repeating 1,0,0,1, 2: random
  function automatic logic ready_for(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return ((t % 4) == 0) || ((t % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_burst(input logic [AW-1:0] a, input int len, input int mode,
                           input bit busy_pulse, input string name);
    logic [DW:0]   exp_q [$];
    int            issued;
    int            exp_done_t;
    bit            hold;
    bit            seen_done;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), mem[(int'(a) + i) % DEPTH]});
    exp_done_t = (len == 0) ? 1 : len + 3;
    issued     = 0;
    hold       = 1'b0;
    seen_done  = 1'b0;
    hold_data  = '0;
    hold_last  = 1'b0;

    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = (AW+1)'(len);
    out_ready = ready_for(mode, 0);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: cmd_ready=%b ram_ren=%b, required 1/0", name, cmd_ready, ram_ren);
    end

    for (int t = 1; t <= len + 60 && !seen_done; t++) begin
      @(posedge clk); #1;
      cmd_valid = busy_pulse && (t == 2);
      cmd_addr  = a ^ 10'h155;
      cmd_len   = 11'd3;
      out_ready = ready_for(mode, t);
      #1;
      n_checks++;
      if (cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_ready t=%0d: cmd_ready=%b required 0", name, t, cmd_ready);
      end
      if (mode == 0) begin
        n_checks++;
        if (ram_ren !== (t >= 1 && t <= len) || out_valid !== (t >= 3 && t <= len + 2) ||
            done !== (t == exp_done_t)) begin
          n_fail++;
          $display("FAIL %s timing t=%0d: ren=%b valid=%b done=%b, required %b/%b/%b", name, t,
                   ram_ren, out_valid, done, (t >= 1 && t <= len), (t >= 3 && t <= len + 2),
                   (t == exp_done_t));
        end
      end
      if (ram_ren) begin
        n_checks++;
        if (issued >= len || ram_raddr !== AW'((int'(a) + issued) % DEPTH)) begin
          n_fail++;
          $display("FAIL %s raddr #%0d: got %h, required %h (len %0d)", name, issued, ram_raddr,
                   AW'((int'(a) + issued) % DEPTH), len);
        end
        issued++;
      end
      if (hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last) begin
          n_fail++;
          $display("FAIL %s stable t=%0d: valid=%b data=%h last=%b, required 1/%h/%b", name, t,
                   out_valid, out_data, out_last, hold_data, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat t=%0d: data=%h, required no beat", name, t, out_data);
        end else begin
          if ({out_last, out_data} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s beat t=%0d: last/data=%b/%h, required %b/%h", name, t, out_last,
                     out_data, exp_q[0][DW], exp_q[0][DW-1:0]);
          end
          void'(exp_q.pop_front());
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (done) begin
        seen_done = 1'b1;
        n_checks++;
        if (exp_q.size() != 0 || issued != len) begin
          n_fail++;
          $display("FAIL %s done: beats left=%0d reads=%0d, required 0/%0d", name, exp_q.size(),
                   issued, len);
        end
      end
    end
    cmd_valid = 1'b0;
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: done not seen, required within %0d cycles", name, len + 60);
    end

    @(posedge clk); #2;
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_done: cmd_ready=%b done=%b, required 1/0", name, cmd_ready, done);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || ram_ren !== 1'b0 || ram_raddr !== '0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_last !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b ren=%b raddr=%h valid=%b data=%h last=%b done=%b, required 1/0/0/0/0/0/0",
               cmd_ready, ram_ren, ram_raddr, out_valid, out_data, out_last, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = 10'h100;
    cmd_len   = 11'd8;
    out_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || ram_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: valid=%b ren=%b, required 1/1", out_valid, ram_ren);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || ram_ren !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_post: valid=%b ren=%b rdy=%b done=%b, required 0/0/1/0", out_valid,
               ram_ren, cmd_ready, done);
    end
    run_burst(10'h020, 2, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int n = 0; n < 24; n++) begin
      int len;
      len = int'($urandom_range(0, 40));
      run_burst(AW'($urandom), len, int'($urandom_range(0, 2)), (len > 0) && ($urandom_range(0, 1) == 1),
                "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    test_reset();
    run_burst(10'h010, 4, 0, 1'b0, "streaming");
    run_burst(10'h040, 8, 1, 1'b0, "backpressure");
    run_burst(10'h3FE, 4, 0, 1'b0, "wrap");
    run_burst(10'h123, 0, 0, 1'b0, "len_zero");
    run_burst(10'h200, DEPTH, 0, 1'b0, "full_depth");
    test_reset_mid_burst();
    run_burst(10'h080, 6, 0, 1'b1, "cmd_while_busy");
    run_burst(10'h300, 12, 2, 1'b1, "busy_random_ready");
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Read-side initiator for the dual-port block RAM.
- Accepts a burst command (base address, length) and drives the RAM read port (ren/raddr).
- Absorbs the RAM's one-cycle registered read latency and presents the data as a valid/ready stream with a last flag.
- Sits between the on-chip dual-port memory and any streaming consumer; the RAM write port is untouched.

Parameters:
- ADDR_WIDTH, 10, RAM address width; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM word width and stream data width.

Ports:
- clk  in  1  single clock for the block; must be the same clock that drives the RAM read port.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  ADDR_WIDTH+1  burst length in words, 0..2**ADDR_WIDTH.
- ram_ren  out  1  RAM read enable.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_ren; RAM holds it while ram_ren=0.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_WIDTH  stream data word.
- out_last  out  1  marks final word of the burst.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk): state=IDLE, cmd_ready=1 after release, ram_ren=0, ram_raddr=0, out_valid=0, out_data=0, out_last=0, done=0, buffer empty, inflight=0.
- rst overrides any operation mid-burst: the burst is abandoned and no further ren is issued. An in-flight RAM word returning after rst is discarded.
- States:
  - IDLE: cmd_ready=1. On handshake, latch addr/len and set remaining=cmd_len.
    - len>0 -> RUN.
    - len=0 -> DONE with no RAM access.
  - RUN: issue reads. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait until buffer is empty and inflight=0, after the last handshake.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read issue rule, evaluated each RUN cycle: ram_ren=1 iff remaining>0 and (occ + inflight - pop) < 2.
  - occ = buffer occupancy (0..2).
  - inflight = 1 if ren was asserted last cycle.
  - pop = out_valid&&out_ready.
  - Each issue sends ram_raddr, then increments the address and decrements remaining.
- ram_raddr wraps modulo 2**ADDR_WIDTH; a burst of full depth starting mid-array reads every word exactly once.
- Return path: when inflight=1, ram_rdata is pushed into a 2-entry output buffer at the end of that cycle. The rule above guarantees the buffer never overflows.
- Stream rules:
  - out_valid = buffer non-empty; out_data/out_last come from the buffer head.
  - Once out_valid is asserted, out_data/out_last are held stable until the handshake.
  - out_last=1 only on the word read with remaining==1 at issue.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Latency: command accepted in cycle T -> first ram_ren in T+1 -> first out_valid in T+3.
  - With out_ready held high, one word per cycle is sustained.
  - A burst of N words has its last beat at T+N+2 and done at T+N+3.
- done: pulses in the cycle after the out_last handshake. cmd_ready rises the cycle after done.
- len=0: accepted at T, done=1 at T+1, cmd_ready=1 at T+2, no ram_ren and no stream beats.
- cmd_valid while not in IDLE is ignored; cmd_ready=0.

Decomposition:
- Package dpram_stream_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparam BUF_DEPTH=2;
  - helper function for the issue-credit check.
- Sub-module stream_skid_fifo: 2-entry synchronous FIFO carrying {last,data}.
  - Ports: push/pop/full/empty/occ.
  - Same clk/rst, synchronous active-high reset.
- Top level holds the FSM, address/remaining counters and the inflight flag.

Test Plan:
- Streaming: RAM preloaded mem[i]=i, cmd addr=0x010 len=4, out_ready=1.
  - ram_ren at T+1..T+4 with raddr 0x010..0x013.
  - out_data 0x10..0x13 on T+3..T+6, out_last only on 0x13, done at T+7.
- Backpressure: len=8 with out_ready toggling 1,0,0,1 pattern.
  - All 8 words delivered in order, none duplicated.
  - out_data held stable while out_ready=0.
  - occ never exceeds 2; ram_ren stalls accordingly.
- Wrap: cmd addr=0x3FE len=4 (ADDR_WIDTH=10) -> raddr sequence 0x3FE,0x3FF,0x000,0x001, data matches.
- Boundaries: len=0 -> done at T+1, no ram_ren, no out_valid. len=1024 from addr 0x200 -> 1024 beats, exactly one out_last.
- Reset mid-burst: rst=1 for one cycle while out_valid=1 and inflight=1.
  - Next cycle: out_valid=0, ram_ren=0, cmd_ready=1, done=0.
  - A following len=2 command streams correct data with no stale word.
- Command while busy: cmd_valid pulsed during RUN with other addr -> ignored, original burst unaffected.
